// File: rtl/mem_pkg.sv
// Shared encodings for the memory-stage access controller.
package mem_pkg;

  typedef enum logic [2:0] {
    LT_LBU = 3'b001,
    LT_LB  = 3'b010,
    LT_LHU = 3'b011,
    LT_LH  = 3'b100,
    LT_LW  = 3'b111
  } load_type_e;

  typedef enum logic [1:0] {
    ST_SB = 2'b01,
    ST_SH = 2'b10,
    ST_SW = 2'b11
  } store_type_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/store_lane_gen.sv
// Byte enables and lane-replicated write data for a store at a given byte offset.
module store_lane_gen
  import mem_pkg::*;
(
  input  logic [1:0]  store_type,
  input  logic [1:0]  offset,
  input  logic [31:0] src,
  output logic [3:0]  byteen,
  output logic [31:0] wdata
);

  always_comb begin
    byteen = '0;
    wdata  = '0;
    case (store_type)
      ST_SW: begin
        byteen = '1;
        wdata  = src;
      end
      ST_SH: begin
        byteen = offset[1] ? 4'b1100 : 4'b0011;
        wdata  = {2{src[15:0]}};
      end
      ST_SB: begin
        byteen = 4'b0001 << offset;
        wdata  = {4{src[7:0]}};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// M-stage data bus controller: alignment check, req/ack transaction with timeout,
// pipeline stall, and registered load return for the W stage.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m_valid,
  input  logic        m_load,
  input  logic        m_store,
  input  logic [31:0] m_addr,
  input  logic [31:0] m_wdata,
  input  logic [2:0]  m_load_type,
  input  logic [1:0]  m_store_type,
  input  logic        flush,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_byteen,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        stall,
  output logic        exc_adel,
  output logic        exc_ades,
  output logic        bus_err,
  output logic        rd_valid,
  output logic [31:0] rd_data,
  output logic [1:0]  rd_byte_addr,
  output logic [2:0]  rd_load_type
);

  localparam int unsigned CW = $clog2(TIMEOUT);

  state_e        state, state_next;
  logic [CW-1:0] cnt;
  logic          lat_we;
  logic [31:0]   lat_addr;
  logic [3:0]    lat_byteen;
  logic [31:0]   lat_wdata;
  logic [1:0]    lat_off;
  logic [2:0]    lat_type;
  logic          drop;

  logic          idle, busy;
  logic          load_aligned, store_aligned, aligned;
  logic          accept, timeout_hit;
  logic [3:0]    lane_byteen;
  logic [31:0]   lane_wdata;

  store_lane_gen u_lane (
    .store_type (m_store_type),
    .offset     (m_addr[1:0]),
    .src        (m_wdata),
    .byteen     (lane_byteen),
    .wdata      (lane_wdata)
  );

  always_comb begin
    load_aligned = 1'b1;
    case (m_load_type)
      LT_LW:        load_aligned = (m_addr[1:0] == 2'b00);
      LT_LH, LT_LHU: load_aligned = ~m_addr[0];
      default: ;
    endcase
    store_aligned = 1'b1;
    case (m_store_type)
      ST_SW:   store_aligned = (m_addr[1:0] == 2'b00);
      ST_SH:   store_aligned = ~m_addr[0];
      default: ;
    endcase
  end

  assign idle        = (state == S_IDLE);
  assign busy        = (state == S_BUSY);
  assign aligned     = m_load ? load_aligned : store_aligned;
  assign accept      = idle & m_valid & (m_load | m_store) & aligned & ~flush;
  assign timeout_hit = busy & ~bus_ack & (cnt == CW'(TIMEOUT - 1));

  // A load wins if both type flags are set, so only one exception can fire.
  assign exc_adel = idle & m_valid & m_load & ~load_aligned & ~flush;
  assign exc_ades = idle & m_valid & m_store & ~m_load & ~store_aligned & ~flush;
  assign stall    = accept | (busy & ~bus_ack & ~timeout_hit);

  assign bus_req    = busy;
  assign bus_we     = busy & lat_we;
  assign bus_addr   = busy ? lat_addr   : '0;
  assign bus_byteen = busy ? lat_byteen : '0;
  assign bus_wdata  = busy ? lat_wdata  : '0;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (accept) state_next = S_BUSY;
      S_BUSY:  if (bus_ack | timeout_hit) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt          <= '0;
      lat_we       <= 1'b0;
      lat_addr     <= '0;
      lat_byteen   <= '0;
      lat_wdata    <= '0;
      lat_off      <= '0;
      lat_type     <= '0;
      drop         <= 1'b0;
      bus_err      <= 1'b0;
      rd_valid     <= 1'b0;
      rd_data      <= '0;
      rd_byte_addr <= '0;
      rd_load_type <= '0;
    end else begin
      rd_valid <= 1'b0;
      bus_err  <= timeout_hit;
      if (accept) begin
        cnt        <= '0;
        lat_we     <= ~m_load;
        lat_addr   <= {m_addr[31:2], 2'b00};
        lat_byteen <= m_load ? 4'b1111 : lane_byteen;
        lat_wdata  <= m_load ? '0 : lane_wdata;
        lat_off    <= m_addr[1:0];
        lat_type   <= m_load_type;
        drop       <= 1'b0;
      end else if (busy) begin
        cnt <= cnt + 1'b1;
        if (flush) drop <= 1'b1;
      end
      // A flush in the completing cycle also kills the W-stage handoff.
      if (busy & bus_ack & ~lat_we) begin
        rd_data      <= bus_rdata;
        rd_byte_addr <= lat_off;
        rd_load_type <= lat_type;
        rd_valid     <= ~drop & ~flush;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized scoreboard bench for mem_access_unit against a size/offset arithmetic model.
module tb_mem_access_unit;

  localparam int unsigned TO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        m_valid, m_load, m_store, flush;
  logic [31:0] m_addr, m_wdata;
  logic [2:0]  m_load_type;
  logic [1:0]  m_store_type;
  logic        bus_req, bus_we, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_byteen;
  logic        stall, exc_adel, exc_ades, bus_err, rd_valid;
  logic [31:0] rd_data;
  logic [1:0]  rd_byte_addr;
  logic [2:0]  rd_load_type;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .m_valid(m_valid), .m_load(m_load), .m_store(m_store),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_load_type(m_load_type), .m_store_type(m_store_type),
    .flush(flush), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_byteen(bus_byteen), .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .stall(stall), .exc_adel(exc_adel), .exc_ades(exc_ades), .bus_err(bus_err),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_byte_addr(rd_byte_addr), .rd_load_type(rd_load_type)
  );

  typedef struct {logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wd;} bus_t;
  typedef struct {logic [31:0] d; logic [1:0] off; logic [2:0] lt;} rd_t;

  bus_t        exp_bus[$];
  rd_t         exp_rd[$];
  int unsigned exp_stall[$];
  int unsigned exp_err[$];
  int unsigned total = 0, bad = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endfunction

  function automatic void check_true(string name, logic cond);
    total++;
    if (cond !== 1'b1) begin
      bad++;
      $display("FAIL %s: condition false", name);
    end
  endfunction

  // Access width in bytes from the instruction's type code.
  function automatic int unsigned acc_size(logic ld, logic [2:0] lt, logic [1:0] st);
    if (ld) begin
      if (lt == 3'b111) return 4;
      if (lt == 3'b011 || lt == 3'b100) return 2;
      return 1;
    end
    if (st == 2'b11) return 4;
    if (st == 2'b10) return 2;
    return 1;
  endfunction

  // ---------------- monitor ----------------
  bus_t        cur;
  logic        have_cur = 1'b0;
  logic        req_q = 1'b0;
  int unsigned run = 0;
  rd_t         rexp;
  int unsigned sexp;

  always @(negedge clk) begin
    if (bus_req) begin
      if (!req_q) begin
        check_true("bus_expected", exp_bus.size() != 0);
        have_cur = (exp_bus.size() != 0);
        if (have_cur) cur = exp_bus.pop_front();
      end
      if (have_cur) begin
        check("bus_we", bus_we, cur.we);
        check("bus_addr", bus_addr, cur.addr);
        check("bus_byteen", bus_byteen, cur.be);
        if (cur.we) check("bus_wdata", bus_wdata, cur.wd);
      end
    end else have_cur = 1'b0;
    req_q = bus_req;

    if (stall) run++;
    else if (run != 0) begin
      check_true("stall_expected", exp_stall.size() != 0);
      sexp = (exp_stall.size() != 0) ? exp_stall.pop_front() : 0;
      check("stall_cycles", run, sexp);
      run = 0;
    end

    if (rd_valid) begin
      check_true("rd_expected", exp_rd.size() != 0);
      if (exp_rd.size() != 0) begin
        rexp = exp_rd.pop_front();
        check("rd_data", rd_data, rexp.d);
        check("rd_byte_addr", {30'd0, rd_byte_addr}, {30'd0, rexp.off});
        check("rd_load_type", {29'd0, rd_load_type}, {29'd0, rexp.lt});
      end
    end

    if (bus_err) begin
      check_true("err_expected", exp_err.size() != 0);
      if (exp_err.size() != 0) void'(exp_err.pop_front());
    end
  end

  // ---------------- driver ----------------
  // Called just after a rising edge with the DUT idle; returns just after a rising edge.
  task automatic issue(input logic ld, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [2:0] lt, input logic [1:0] stt, input int unsigned delay,
                       input logic [31:0] rdata, input logic fl_issue, input logic fl_busy);
    int unsigned sz, off;
    logic        al, go;
    bus_t        b;
    rd_t         r;
    sz  = acc_size(ld, lt, stt);
    off = addr % 4;
    al  = (addr % sz) == 0;
    go  = al && !fl_issue;
    m_valid = 1'b1; m_load = ld; m_store = !ld; m_addr = addr; m_wdata = wd;
    m_load_type = lt; m_store_type = stt; flush = fl_issue;
    if (go) begin
      b.we   = !ld;
      b.addr = addr - off;
      b.be   = ld ? 4'hf : 4'((((1 << sz) - 1) << off) & 15);
      b.wd   = (sz == 4) ? wd : (sz == 2) ? wd[15:0] * 32'h0001_0001 : wd[7:0] * 32'h0101_0101;
      exp_bus.push_back(b);
      exp_stall.push_back(delay < TO ? delay + 1 : TO);
      if (delay >= TO) exp_err.push_back(1);
      else if (ld && !fl_busy) begin
        r.d = rdata; r.off = addr[1:0]; r.lt = lt;
        exp_rd.push_back(r);
      end
    end
    @(negedge clk);
    check("exc_adel", exc_adel, ld && !al && !fl_issue);
    check("exc_ades", exc_ades, !ld && !al && !fl_issue);
    check("stall_issue", stall, go);
    @(posedge clk) #1;
    flush = 1'b0;
    if (go) begin
      flush = fl_busy;
      if (delay >= TO) begin
        repeat (TO) begin @(posedge clk) #1; flush = 1'b0; end
      end else begin
        repeat (delay) begin @(posedge clk) #1; flush = 1'b0; end
        bus_ack = 1'b1; bus_rdata = rdata;
        @(posedge clk) #1;
        bus_ack = 1'b0; flush = 1'b0; bus_rdata = $urandom;
      end
    end
    m_valid = 1'b0; m_load = 1'b0; m_store = 1'b0;
  endtask

  task automatic reset_mid_busy();
    bus_t b;
    m_valid = 1'b1; m_load = 1'b1; m_store = 1'b0; m_addr = 32'h0000_0040;
    m_load_type = 3'b111; m_store_type = 2'b00;
    b.we = 1'b0; b.addr = 32'h0000_0040; b.be = 4'hf; b.wd = '0;
    exp_bus.push_back(b);
    exp_stall.push_back(4);
    repeat (3) @(posedge clk) #1;
    reset = 1'b1;
    @(posedge clk) #1;
    reset = 1'b0; m_valid = 1'b0; m_load = 1'b0;
    bus_ack = 1'b1; bus_rdata = 32'h5555_AAAA;
    @(negedge clk);
    check("req_after_reset", bus_req, 1'b0);
    check("stall_after_reset", stall, 1'b0);
    @(posedge clk) #1;
    bus_ack = 1'b0;
    @(negedge clk);
    check("rd_valid_late_ack", rd_valid, 1'b0);
    check("req_late_ack", bus_req, 1'b0);
    @(posedge clk) #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  logic [2:0] lts[5] = '{3'b111, 3'b001, 3'b010, 3'b011, 3'b100};
  logic [1:0] sts[3] = '{2'b11, 2'b10, 2'b01};

  initial begin
    int unsigned rr, dly;
    reset = 1'b1; m_valid = 1'b0; m_load = 1'b0; m_store = 1'b0; flush = 1'b0;
    m_addr = '0; m_wdata = '0; m_load_type = '0; m_store_type = '0;
    bus_ack = 1'b0; bus_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_bus_req", bus_req, 1'b0);
    check("rst_stall", stall, 1'b0);
    check("rst_rd_valid", rd_valid, 1'b0);
    check("rst_bus_err", bus_err, 1'b0);
    check("rst_rd_data", rd_data, 32'h0);
    check("rst_bus_addr", bus_addr, 32'h0);
    @(posedge clk) #1;
    reset = 1'b0;
    @(posedge clk) #1;

    issue(1'b1, 32'h0000_1004, 32'h0, 3'b111, 2'b00, 0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    issue(1'b0, 32'h0000_2003, 32'h0000_00A5, 3'b000, 2'b01, 1, 32'h0, 1'b0, 1'b0);
    issue(1'b0, 32'h0000_0002, 32'h0000_1234, 3'b000, 2'b10, 0, 32'h0, 1'b0, 1'b0);
    issue(1'b1, 32'h0000_0001, 32'h0, 3'b100, 2'b00, 0, 32'h0, 1'b0, 1'b0);
    issue(1'b0, 32'h0000_0106, 32'hCAFE_F00D, 3'b000, 2'b11, 0, 32'h0, 1'b0, 1'b0);
    issue(1'b1, 32'h0000_3001, 32'h0, 3'b001, 2'b00, 3, 32'h0102_0304, 1'b0, 1'b0);
    issue(1'b1, 32'h0000_3000, 32'h0, 3'b111, 2'b00, TO - 1, 32'h7777_8888, 1'b0, 1'b0);
    issue(1'b1, 32'h0000_4000, 32'h0, 3'b111, 2'b00, TO, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    check("req_after_timeout", bus_req, 1'b0);
    @(posedge clk) #1;
    reset_mid_busy();
    issue(1'b1, 32'h0000_5000, 32'h0, 3'b111, 2'b00, 0, 32'h1111_2222, 1'b1, 1'b0);
    issue(1'b1, 32'h0000_5003, 32'h0, 3'b111, 2'b00, 0, 32'h1111_2222, 1'b1, 1'b0);
    issue(1'b1, 32'h0000_5002, 32'h0, 3'b011, 2'b00, 2, 32'h3333_4444, 1'b0, 1'b1);
    issue(1'b1, 32'h0000_5001, 32'h0, 3'b010, 2'b00, 0, 32'h3333_4444, 1'b0, 1'b1);

    for (int i = 0; i < 250; i++) begin
      logic ld;
      ld  = 1'($urandom % 2);
      rr  = $urandom % 10;
      dly = (rr == 9) ? TO : rr % 5;
      issue(ld, $urandom, $urandom, lts[$urandom % 5], sts[$urandom % 3], dly, $urandom,
            ($urandom % 12) == 0, ($urandom % 8) == 0);
    end

    repeat (4) @(posedge clk);
    @(negedge clk);
    check("left_bus", exp_bus.size(), 0);
    check("left_rd", exp_rd.size(), 0);
    check("left_stall", exp_stall.size(), 0);
    check("left_err", exp_err.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
